// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyzer capture controller.
// Holds the FSM state encoding and the default parameter values.
package la_pkg;

    localparam int LA_DATA_WIDTH = 32;
    localparam int LA_ADDR_WIDTH = 5;
    localparam int LA_CNT_WIDTH  = 16;

    // Encoding is visible on the state output, so the values are fixed.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_WAIT = 3'd2,
        ST_POST = 3'd3,
        ST_DONE = 3'd4
    } la_state_e;

    // States in which probe samples are accepted and written to the FIFO.
    function automatic logic is_capturing(input la_state_e s);
        return (s == ST_PRE) || (s == ST_WAIT) || (s == ST_POST);
    endfunction

endpackage

// File: rtl/la_capture_ctrl_if.sv
// Sample stream plus external FIFO write port of the capture controller.
// The master side is the controller; the slave side is the probe/FIFO environment.
interface la_capture_ctrl_if
    import la_pkg::*;
#(
    parameter int DATA_WIDTH = LA_DATA_WIDTH,
    parameter int ADDR_WIDTH = LA_ADDR_WIDTH
) ();

    logic                  sample_vld;
    logic [DATA_WIDTH-1:0] sample_din;
    logic                  fifo_alfull;
    logic                  fifo_wen;
    logic [DATA_WIDTH-1:0] fifo_din;
    logic [ADDR_WIDTH:0]   fifo_level;

    modport master (
        input  sample_vld,
        input  sample_din,
        input  fifo_alfull,
        output fifo_wen,
        output fifo_din,
        output fifo_level
    );

    modport slave (
        output sample_vld,
        output sample_din,
        output fifo_alfull,
        input  fifo_wen,
        input  fifo_din,
        input  fifo_level
    );

endinterface

// File: rtl/la_trig_cmp.sv
// Masked trigger comparator: hit when every masked bit of the sample equals the value.
// Purely combinational; an all-zero mask always hits.
module la_trig_cmp
    import la_pkg::*;
#(
    parameter int DATA_WIDTH = LA_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] sample,
    input  logic [DATA_WIDTH-1:0] mask,
    input  logic [DATA_WIDTH-1:0] value,
    output logic                  hit
);

    assign hit = ~|((sample ^ value) & mask);

endmodule

// File: rtl/la_capture_ctrl.sv
// Capture controller: stores pre-trigger samples, waits for a masked trigger,
// then stores post-trigger samples into an external FIFO write port.
module la_capture_ctrl
    import la_pkg::*;
#(
    parameter int DATA_WIDTH = LA_DATA_WIDTH,
    parameter int ADDR_WIDTH = LA_ADDR_WIDTH,
    parameter int CNT_WIDTH  = LA_CNT_WIDTH
) (
    input  logic                  wclk,
    input  logic                  w_rst_n,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] trig_mask,
    input  logic [DATA_WIDTH-1:0] trig_val,
    input  logic [ADDR_WIDTH:0]   pre_len,
    input  logic [CNT_WIDTH-1:0]  post_len,
    input  logic [ADDR_WIDTH:0]   alfull_lvl,
    la_capture_ctrl_if.master     bus,
    output logic [2:0]            state,
    output logic                  triggered,
    output logic                  done,
    output logic                  overflow
);

    localparam logic [ADDR_WIDTH:0]  PRE_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] POST_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    la_state_e             state_q;
    logic [ADDR_WIDTH:0]   pre_cnt;
    logic [ADDR_WIDTH:0]   pre_cnt_nxt;
    logic [CNT_WIDTH-1:0]  post_cnt;
    logic [CNT_WIDTH-1:0]  post_cnt_nxt;
    logic [CNT_WIDTH-1:0]  post_eff;
    logic                  fifo_wen_q;
    logic [DATA_WIDTH-1:0] fifo_din_q;
    logic                  capturing;
    logic                  accept;
    logic                  drop;
    logic                  trig_hit;

    la_trig_cmp #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_trig_cmp (
        .sample (bus.sample_din),
        .mask   (trig_mask),
        .value  (trig_val),
        .hit    (trig_hit)
    );

    // A zero post length still captures the trigger sample itself.
    assign post_eff  = (post_len == '0) ? POST_ONE : post_len;
    assign capturing = is_capturing(state_q);
    assign accept    = capturing & bus.sample_vld & ~bus.fifo_alfull;
    assign drop      = capturing & bus.sample_vld &  bus.fifo_alfull;

    // Counters saturate instead of wrapping so equality checks can never be skipped past.
    assign pre_cnt_nxt  = (pre_cnt  == '1) ? pre_cnt  : pre_cnt  + PRE_ONE;
    assign post_cnt_nxt = (post_cnt == '1) ? post_cnt : post_cnt + POST_ONE;

    assign bus.fifo_wen   = fifo_wen_q;
    assign bus.fifo_din   = fifo_din_q;
    assign bus.fifo_level = alfull_lvl;
    assign state          = state_q;

    // Single FSM process; FIFO write port and status flags are registered here.
    always_ff @(posedge wclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q    <= ST_IDLE;
            pre_cnt    <= '0;
            post_cnt   <= '0;
            fifo_wen_q <= 1'b0;
            fifo_din_q <= '0;
            triggered  <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            fifo_wen_q <= 1'b0;
            if (abort) begin
                state_q <= ST_IDLE;
                done    <= 1'b0;
            end else begin
                if (accept) begin
                    fifo_wen_q <= 1'b1;
                    fifo_din_q <= bus.sample_din;
                end
                if (drop) begin
                    overflow <= 1'b1;
                end
                case (state_q)
                    ST_IDLE, ST_DONE: begin
                        if (arm) begin
                            triggered <= 1'b0;
                            done      <= 1'b0;
                            overflow  <= 1'b0;
                            pre_cnt   <= '0;
                            post_cnt  <= '0;
                            state_q   <= (pre_len != '0) ? ST_PRE : ST_WAIT;
                        end
                    end
                    ST_PRE: begin
                        if (accept) begin
                            pre_cnt <= pre_cnt_nxt;
                            if (pre_cnt_nxt == pre_len) begin
                                state_q <= ST_WAIT;
                            end
                        end
                    end
                    ST_WAIT: begin
                        // The trigger sample is the first post sample.
                        if (accept && trig_hit) begin
                            triggered <= 1'b1;
                            post_cnt  <= POST_ONE;
                            if (post_eff == POST_ONE) begin
                                state_q <= ST_DONE;
                                done    <= 1'b1;
                            end else begin
                                state_q <= ST_POST;
                            end
                        end
                    end
                    ST_POST: begin
                        if (accept) begin
                            post_cnt <= post_cnt_nxt;
                            if (post_cnt_nxt == post_eff) begin
                                state_q <= ST_DONE;
                                done    <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_la_capture_ctrl.sv
// Self-checking bench for la_capture_ctrl: directed scenarios plus randomized
// captures compared cycle by cycle against a behavioural capture model.
module tb_la_capture_ctrl;
    import la_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 16;

    logic          wclk       = 1'b0;
    logic          w_rst_n    = 1'b0;
    logic          arm        = 1'b0;
    logic          abort      = 1'b0;
    logic [DW-1:0] trig_mask  = '0;
    logic [DW-1:0] trig_val   = '0;
    logic [AW:0]   pre_len    = '0;
    logic [CW-1:0] post_len   = '0;
    logic [AW:0]   alfull_lvl = '0;
    logic [2:0]    state;
    logic          triggered;
    logic          done;
    logic          overflow;

    la_capture_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    la_capture_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .CNT_WIDTH  (CW)
    ) dut (
        .wclk       (wclk),
        .w_rst_n    (w_rst_n),
        .arm        (arm),
        .abort      (abort),
        .trig_mask  (trig_mask),
        .trig_val   (trig_val),
        .pre_len    (pre_len),
        .post_len   (post_len),
        .alfull_lvl (alfull_lvl),
        .bus        (bus),
        .state      (state),
        .triggered  (triggered),
        .done       (done),
        .overflow   (overflow)
    );

    always #5 wclk = ~wclk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: phase 0 idle, 1 collecting pre samples, 2 hunting trigger, 3 collecting post, 4 finished.
    int            m_phase;
    int            m_pre_seen;
    int            m_post_seen;
    logic          m_trig, m_done, m_ovf, m_wen;
    logic [DW-1:0] m_din;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] act_q[$];

    always @(negedge wclk) begin
        if (bus.fifo_wen === 1'b1) act_q.push_back(bus.fifo_din);
    end

    task automatic model_reset();
        m_phase = 0; m_pre_seen = 0; m_post_seen = 0;
        m_trig = 1'b0; m_done = 1'b0; m_ovf = 1'b0; m_wen = 1'b0; m_din = '0;
    endtask

    task automatic clear_logs();
        exp_q.delete();
        act_q.delete();
    endtask

    task automatic model_update(input logic a, input logic ab, input logic v,
                                input logic [DW-1:0] d, input logic af);
        int want_post;
        want_post = (post_len == 0) ? 1 : int'(post_len);
        m_wen = 1'b0;
        if (ab) begin
            m_phase = 0;
            m_done  = 1'b0;
        end else if (m_phase == 0 || m_phase == 4) begin
            if (a) begin
                m_trig = 1'b0; m_done = 1'b0; m_ovf = 1'b0;
                m_pre_seen = 0; m_post_seen = 0;
                m_phase = (pre_len != 0) ? 1 : 2;
            end
        end else begin
            if (v && af) m_ovf = 1'b1;
            if (v && !af) begin
                m_wen = 1'b1;
                m_din = d;
                exp_q.push_back(d);
                if (m_phase == 1) begin
                    m_pre_seen++;
                    if (m_pre_seen == int'(pre_len)) m_phase = 2;
                end else if (m_phase == 2) begin
                    if (((d ^ trig_val) & trig_mask) == '0) begin
                        m_trig = 1'b1;
                        m_post_seen = 1;
                        if (m_post_seen == want_post) begin m_phase = 4; m_done = 1'b1; end
                        else m_phase = 3;
                    end
                end else begin
                    m_post_seen++;
                    if (m_post_seen == want_post) begin m_phase = 4; m_done = 1'b1; end
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic a, input logic ab, input logic v,
                                 input logic [DW-1:0] d, input logic af);
        @(negedge wclk);
        arm = a; abort = ab;
        bus.sample_vld = v; bus.sample_din = d; bus.fifo_alfull = af;
        @(posedge wclk);
        model_update(a, ab, v, d, af);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic test_reset();
        w_rst_n = 1'b0;
        alfull_lvl = 6'($urandom_range(1, 63));
        repeat (2) @(posedge wclk);
        #1;
        n_cmp++; if (state !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_state: got %0d expected 0", state); end
        n_cmp++; if (bus.fifo_wen !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_wen: got %0b expected 0", bus.fifo_wen); end
        n_cmp++; if (bus.fifo_din !== '0) begin n_fail++; $display("[TB] FAIL reset_din: got %0h expected 0", bus.fifo_din); end
        n_cmp++; if ({triggered, done, overflow} !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_flags: got %b expected 000", {triggered, done, overflow}); end
        n_cmp++; if (bus.fifo_level !== alfull_lvl) begin n_fail++; $display("[TB] FAIL fifo_level: got %0d expected %0d", bus.fifo_level, alfull_lvl); end
        @(negedge wclk);
        w_rst_n = 1'b1;
        model_reset();
        idle();
        n_cmp++; if (bus.fifo_wen !== 1'b0 || state !== 3'd0) begin n_fail++; $display("[TB] FAIL idle_after_reset: got wen=%0b state=%0d expected wen=0 state=0", bus.fifo_wen, state); end
    endtask

    task automatic test_basic_capture();
        logic [DW-1:0] golden [13] = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7,
                                       32'h8, 32'h9, 32'hA, 32'h5A, 32'h20, 32'h21};
        pre_len = 6'd4; post_len = 16'd3; trig_mask = 32'hFF; trig_val = 32'h5A;
        idle(); clear_logs();
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        n_cmp++; if (state !== 3'd1) begin n_fail++; $display("[TB] FAIL basic_arm_pre: got %0d expected 1", state); end
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, DW'(i), 1'b0);
            if (i == 3) begin
                n_cmp++; if (state !== 3'd1) begin n_fail++; $display("[TB] FAIL basic_still_pre: got %0d expected 1", state); end
            end
            if (i == 4) begin
                n_cmp++; if (state !== 3'd2) begin n_fail++; $display("[TB] FAIL basic_pre_to_wait: got %0d expected 2", state); end
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h5A, 1'b0);
        n_cmp++; if (state !== 3'd3 || triggered !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_trigger: got state=%0d trig=%0b expected state=3 trig=1", state, triggered); end
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h20, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h21, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h22, 1'b0);
        idle(); idle();
        n_cmp++; if (done !== 1'b1 || state !== 3'd4) begin n_fail++; $display("[TB] FAIL basic_done: got done=%0b state=%0d expected done=1 state=4", done, state); end
        n_cmp++; if (act_q.size() != 13) begin n_fail++; $display("[TB] FAIL basic_write_count: got %0d expected 13", act_q.size()); end
        for (int i = 0; i < 13 && i < act_q.size(); i++) begin
            n_cmp++; if (act_q[i] !== golden[i]) begin n_fail++; $display("[TB] FAIL basic_write_data[%0d]: got %0h expected %0h", i, act_q[i], golden[i]); end
        end
    endtask

    task automatic test_post_zero();
        pre_len = 6'd2; post_len = 16'd0; trig_mask = '0; trig_val = $urandom;
        idle(); clear_logs();
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b1, $urandom, 1'b0);
        idle();
        n_cmp++; if (act_q.size() != 3) begin n_fail++; $display("[TB] FAIL post0_writes: got %0d expected 3", act_q.size()); end
        n_cmp++; if ({state, triggered, done} !== {3'd4, 1'b1, 1'b1}) begin n_fail++; $display("[TB] FAIL post0_final: got state=%0d trig=%0b done=%0b expected 4/1/1", state, triggered, done); end
    endtask

    task automatic test_overflow();
        pre_len = 6'd0; post_len = 16'd2; trig_mask = '1; trig_val = 32'hDEADBEEF;
        idle(); clear_logs();
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        n_cmp++; if (state !== 3'd2) begin n_fail++; $display("[TB] FAIL ovf_arm_wait: got %0d expected 2", state); end
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1);
        idle();
        n_cmp++; if ({state, triggered, overflow} !== {3'd2, 1'b0, 1'b1}) begin n_fail++; $display("[TB] FAIL ovf_dropped: got state=%0d trig=%0b ovf=%0b expected 2/0/1", state, triggered, overflow); end
        n_cmp++; if (act_q.size() != 0) begin n_fail++; $display("[TB] FAIL ovf_no_write: got %0d expected 0", act_q.size()); end
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
        n_cmp++; if (state !== 3'd3) begin n_fail++; $display("[TB] FAIL ovf_then_post: got %0d expected 3", state); end
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h1234, 1'b0);
        idle();
        n_cmp++; if ({state, overflow, done} !== {3'd4, 1'b1, 1'b1} || act_q.size() != 2) begin n_fail++; $display("[TB] FAIL ovf_finish: got state=%0d ovf=%0b done=%0b writes=%0d expected 4/1/1/2", state, overflow, done, act_q.size()); end
    endtask

    task automatic test_abort();
        pre_len = 6'd0; post_len = 16'd5; trig_mask = '0;
        idle(); clear_logs();
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hA1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hA2, 1'b0);
        n_cmp++; if (state !== 3'd3) begin n_fail++; $display("[TB] FAIL abort_in_post: got %0d expected 3", state); end
        applyStimulus(1'b0, 1'b1, 1'b1, 32'hA3, 1'b0);
        n_cmp++; if ({state, bus.fifo_wen, triggered} !== {3'd0, 1'b0, 1'b1}) begin n_fail++; $display("[TB] FAIL abort_effect: got state=%0d wen=%0b trig=%0b expected 0/0/1", state, bus.fifo_wen, triggered); end
        idle();
        n_cmp++; if (act_q.size() != 2) begin n_fail++; $display("[TB] FAIL abort_writes: got %0d expected 2", act_q.size()); end
        applyStimulus(1'b1, 1'b1, 1'b1, 32'hA4, 1'b0);
        n_cmp++; if (state !== 3'd0) begin n_fail++; $display("[TB] FAIL abort_beats_arm: got %0d expected 0", state); end
    endtask

    task automatic test_reset_mid();
        pre_len = 6'd0; post_len = 16'd4; trig_mask = '0;
        idle();
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hB1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hB2, 1'b1);
        @(negedge wclk);
        arm = 1'b0; abort = 1'b0; bus.sample_vld = 1'b1; bus.sample_din = 32'hB3; bus.fifo_alfull = 1'b0;
        #2 w_rst_n = 1'b0;
        #1;
        n_cmp++; if ({state, bus.fifo_wen, triggered, done, overflow} !== {3'd0, 4'b0000} || bus.fifo_din !== '0) begin n_fail++; $display("[TB] FAIL midreset_values: got state=%0d wen=%0b din=%0h flags=%b expected all zero", state, bus.fifo_wen, bus.fifo_din, {triggered, done, overflow}); end
        @(negedge wclk);
        w_rst_n = 1'b1;
        model_reset();
        @(posedge wclk); #1;
        n_cmp++; if (bus.fifo_wen !== 1'b0 || state !== 3'd0) begin n_fail++; $display("[TB] FAIL midreset_release: got wen=%0b state=%0d expected 0/0", bus.fifo_wen, state); end
        clear_logs();
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        n_cmp++; if ({state, triggered, done, overflow} !== {3'd2, 3'b000}) begin n_fail++; $display("[TB] FAIL midreset_rearm: got state=%0d flags=%b expected 2/000", state, {triggered, done, overflow}); end
    endtask

    task automatic test_arm_ignored();
        pre_len = 6'd3; post_len = 16'd2; trig_mask = 32'hFF; trig_val = 32'h77;
        idle(); clear_logs();
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h11, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h12, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h13, 1'b0);
        n_cmp++; if (state !== 3'd2) begin n_fail++; $display("[TB] FAIL arm_in_pre: got %0d expected 2", state); end
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h10, 1'b0);
        n_cmp++; if (state !== 3'd2) begin n_fail++; $display("[TB] FAIL arm_in_wait: got %0d expected 2", state); end
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h177, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h99, 1'b0);
        n_cmp++; if (state !== 3'd4 || done !== 1'b1) begin n_fail++; $display("[TB] FAIL arm_then_done: got state=%0d done=%0b expected 4/1", state, done); end
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        n_cmp++; if ({state, done, triggered} !== {3'd1, 1'b0, 1'b0}) begin n_fail++; $display("[TB] FAIL arm_in_done: got state=%0d done=%0b trig=%0b expected 1/0/0", state, done, triggered); end
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
    endtask

    task automatic test_random();
        logic [DW-1:0] masks [4] = '{32'h0, 32'h1, 32'h3, 32'h7};
        for (int run = 0; run < 40; run++) begin
            idle(); clear_logs();
            pre_len   = 6'($urandom_range(0, 6));
            post_len  = 16'($urandom_range(0, 5));
            trig_mask = masks[$urandom_range(0, 3)];
            trig_val  = $urandom;
            applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
            for (int cyc = 0; cyc < 60; cyc++) begin
                applyStimulus(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 2),
                              ($urandom_range(0, 99) < 75), $urandom,
                              ($urandom_range(0, 99) < 20));
                n_cmp++;
                if ({state, triggered, done, overflow, bus.fifo_wen} !== {3'(m_phase), m_trig, m_done, m_ovf, m_wen}) begin
                    n_fail++;
                    $display("[TB] FAIL rand_outputs run%0d cyc%0d: got st=%0d t=%0b d=%0b o=%0b w=%0b expected st=%0d t=%0b d=%0b o=%0b w=%0b",
                             run, cyc, state, triggered, done, overflow, bus.fifo_wen, m_phase, m_trig, m_done, m_ovf, m_wen);
                end
                if (m_wen) begin
                    n_cmp++;
                    if (bus.fifo_din !== m_din) begin n_fail++; $display("[TB] FAIL rand_din run%0d cyc%0d: got %0h expected %0h", run, cyc, bus.fifo_din, m_din); end
                end
            end
            idle();
            n_cmp++;
            if (act_q != exp_q) begin n_fail++; $display("[TB] FAIL rand_write_log run%0d: got %0d writes expected %0d", run, act_q.size(), exp_q.size()); end
        end
    endtask

    initial begin
        bus.sample_vld = 1'b0; bus.sample_din = '0; bus.fifo_alfull = 1'b0;
        model_reset();
        test_reset();
        test_basic_capture();
        test_post_zero();
        test_overflow();
        test_abort();
        test_reset_mid();
        test_arm_ignored();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/la_capture_ctrl.md
LA_CAPTURE_CTRL -- requirements
Module: la_capture_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32, sample and FIFO data width.
REQ-002 Parameter ADDR_WIDTH, default 5, FIFO address width; level/pre-length width is ADDR_WIDTH+1.
REQ-003 Parameter CNT_WIDTH, default 16, post-trigger counter width.
REQ-004 wclk  input  1  capture clock; all logic on posedge wclk.
REQ-005 w_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 arm  input  1  single-cycle start pulse.
REQ-007 abort  input  1  single-cycle stop pulse; overrides arm.
REQ-008 trig_mask  input  DATA_WIDTH  bits participating in trigger compare.
REQ-009 trig_val  input  DATA_WIDTH  trigger compare value.
REQ-010 pre_len  input  ADDR_WIDTH+1  samples to store before trigger is enabled.
REQ-011 post_len  input  CNT_WIDTH  samples to store from trigger sample inclusive; 0 treated as 1.
REQ-012 alfull_lvl  input  ADDR_WIDTH+1  almost-full threshold, forwarded to FIFO.
REQ-013 sample_vld  input  1  sample_din valid this cycle.
REQ-014 sample_din  input  DATA_WIDTH  probe sample.
REQ-015 fifo_alfull  input  1  FIFO write-side almost-full.
REQ-016 fifo_wen  output  1  FIFO write enable, registered.
REQ-017 fifo_din  output  DATA_WIDTH  FIFO write data, registered.
REQ-018 fifo_level  output  ADDR_WIDTH+1  equals alfull_lvl, combinational.
REQ-019 state  output  3  FSM state encoding.
REQ-020 triggered  output  1  sticky, trigger seen this capture.
REQ-021 done  output  1  capture complete, held.
REQ-022 overflow  output  1  sticky, a sample dropped due to fifo_alfull.

Function
REQ-023 FSM states: IDLE=0, PRE=1, WAIT=2, POST=3, DONE=4.
REQ-024 IDLE/DONE + arm -> PRE if pre_len!=0, else WAIT; clears triggered, done, overflow, counters.
REQ-025 arm in PRE/WAIT/POST ignored.
REQ-026 abort in any state -> IDLE next cycle; no fifo_wen issued for that cycle's sample; sticky flags retained.
REQ-027 Accepted sample = sample_vld & ~fifo_alfull in PRE/WAIT/POST; written with fifo_wen=1, fifo_din=sample_din, one cycle later.
REQ-028 sample_vld & fifo_alfull in PRE/WAIT/POST: sample dropped, overflow<=1, no counter advance.
REQ-029 PRE: pre counter increments per accepted sample; at count==pre_len -> WAIT (transition on the cycle the pre_len-th sample is accepted).
REQ-030 Trigger hit = ((sample_din ^ trig_val) & trig_mask)==0; trig_mask=0 triggers on first accepted sample in WAIT.
REQ-031 Trigger not evaluated in PRE.
REQ-032 WAIT + accepted sample with hit -> POST (or DONE if effective post_len==1); triggered<=1; trigger sample written and counted as post sample 1.
REQ-033 WAIT + accepted sample without hit: written, remains WAIT.
REQ-034 POST: post counter increments per accepted sample; when count reaches effective post_len -> DONE.
REQ-035 DONE: fifo_wen=0, done=1 until arm or abort.
REQ-036 Counters do not wrap; comparisons are equality at full CNT_WIDTH / ADDR_WIDTH+1 width.
REQ-037 fifo_wen=0 in IDLE and DONE regardless of sample_vld.

Reset
REQ-038 On w_rst_n low: state=IDLE, fifo_wen=0, fifo_din=0, triggered=0, done=0, overflow=0, counters=0.
REQ-039 Reset mid-capture discards progress; no fifo_wen in the cycle after release.

Structure
REQ-040 State encodings and default parameter values in shared package la_pkg.
REQ-041 Trigger comparator as sub-module la_trig_cmp (mask/value compare, combinational).
REQ-042 No FIFO instance inside; block drives an external ASYN_FIFO write port.

Verification
REQ-043 pre_len=4, post_len=3, trig_mask=0xFF, trig_val=0x5A, samples 1..10 then 0x5A then 0x20..0x22 -> writes 1..10, 0x5A, 0x20, 0x21; done=1; 13 fifo_wen pulses total.
REQ-044 post_len=0, trig_mask=0 -> after pre phase, exactly one post write, DONE, triggered=1.
REQ-045 fifo_alfull=1 for 2 cycles with sample_vld=1 in WAIT -> 2 samples dropped, overflow=1, counters unchanged.
REQ-046 abort asserted in POST with sample_vld=1 -> state=IDLE next cycle, no write for that sample, triggered stays 1.
REQ-047 w_rst_n low during POST -> all outputs at reset values, arm then restarts cleanly with flags cleared.
REQ-048 arm pulse in WAIT -> ignored, counters unchanged; arm in DONE -> restart into PRE with done=0.
